// File: rtl/regfile_burst_ctrl.sv
// Burst controller for an external register file.
// Accepts single-beat commands describing a write or read burst of up to 64 words,
// then streams write data into the register file one word per cycle, or fetches and
// presents read data one word every two cycles through a valid/ready output stream.
// Addresses advance modulo DEPTH, so bursts longer than the file revisit entries in order.
module regfile_burst_ctrl #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,

    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_write,
    input  logic [5:0]       cmd_addr,
    input  logic [5:0]       cmd_len,

    input  logic             wdata_valid,
    output logic             wdata_ready,
    input  logic [WIDTH-1:0] wdata,

    output logic             rdata_valid,
    input  logic             rdata_ready,
    output logic [WIDTH-1:0] rdata,

    output logic             rf_we,
    output logic [5:0]       rf_select,
    output logic [WIDTH-1:0] rf_write_data,
    input  logic [WIDTH-1:0] rf_read_out,

    output logic             busy,
    output logic             err
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WBURST = 2'd1,
        RFETCH = 2'd2,
        RHOLD  = 2'd3
    } state_t;

    // Depth widened to 7 bits so DEPTH = 64 compares correctly against 6-bit addresses.
    localparam logic [6:0] DEPTH_W = 7'(DEPTH);

    state_t           state;
    state_t           state_nxt;
    logic [5:0]       addr;
    logic [5:0]       addr_nxt;
    logic [5:0]       remaining;
    logic [5:0]       remaining_nxt;
    logic [5:0]       sel_hold;
    logic [WIDTH-1:0] rdata_nxt;
    logic             rdata_valid_nxt;
    logic             err_nxt;
    logic             cmd_bad;

    // Next entry index, wrapping from DEPTH-1 back to entry 0.
    function automatic logic [5:0] wrap_inc(input logic [5:0] a);
        logic [5:0] r;
        if ({1'b0, a} == DEPTH_W - 7'd1) begin
            r = 6'd0;
        end else begin
            r = a + 6'd1;
        end
        return r;
    endfunction

    // A start entry beyond the register file is rejected without any access.
    assign cmd_bad       = ({1'b0, cmd_addr} >= DEPTH_W);

    // Write data passes straight through; rf_we alone qualifies it.
    assign rf_write_data = wdata;

    assign busy          = (state != IDLE);

    // State, burst bookkeeping and read-data registers; rst aborts any burst at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= 6'd0;
            remaining   <= 6'd0;
            rdata       <= '0;
            rdata_valid <= 1'b0;
            err         <= 1'b0;
            sel_hold    <= 6'd0;
        end else begin
            state       <= state_nxt;
            addr        <= addr_nxt;
            remaining   <= remaining_nxt;
            rdata       <= rdata_nxt;
            rdata_valid <= rdata_valid_nxt;
            err         <= err_nxt;
            sel_hold    <= rf_select;
        end
    end

    // Next-state logic and per-state outputs; rf_select falls back to its last driven value.
    always_comb begin
        state_nxt       = state;
        addr_nxt        = addr;
        remaining_nxt   = remaining;
        rdata_nxt       = rdata;
        rdata_valid_nxt = rdata_valid;
        err_nxt         = 1'b0;
        cmd_ready       = 1'b0;
        wdata_ready     = 1'b0;
        rf_we           = 1'b0;
        rf_select       = sel_hold;

        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    if (cmd_bad) begin
                        err_nxt = 1'b1;
                    end else begin
                        addr_nxt      = cmd_addr;
                        remaining_nxt = cmd_len;
                        state_nxt     = cmd_write ? WBURST : RFETCH;
                    end
                end
            end

            WBURST: begin
                wdata_ready = 1'b1;
                rf_we       = wdata_valid;
                rf_select   = addr;
                if (wdata_valid) begin
                    addr_nxt = wrap_inc(addr);
                    if (remaining == 6'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        remaining_nxt = remaining - 6'd1;
                    end
                end
            end

            RFETCH: begin
                rf_select       = addr;
                rdata_nxt       = rf_read_out;
                rdata_valid_nxt = 1'b1;
                state_nxt       = RHOLD;
            end

            RHOLD: begin
                rf_select = addr;
                if (rdata_ready) begin
                    rdata_valid_nxt = 1'b0;
                    if (remaining == 6'd0) begin
                        state_nxt = IDLE;
                    end else begin
                        addr_nxt      = wrap_inc(addr);
                        remaining_nxt = remaining - 6'd1;
                        state_nxt     = RFETCH;
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_regfile_burst_ctrl.sv
// Bench for regfile_burst_ctrl: models the register file, keeps a golden image of
// its contents and checks every write beat and read beat against it.
module tb_regfile_burst_ctrl;

    localparam int WIDTH = 32;
    localparam int DEPTH = 32;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_write;
    logic [5:0]       cmd_addr;
    logic [5:0]       cmd_len;
    logic             wdata_valid;
    logic             wdata_ready;
    logic [WIDTH-1:0] wdata;
    logic             rdata_valid;
    logic             rdata_ready;
    logic [WIDTH-1:0] rdata;
    logic             rf_we;
    logic [5:0]       rf_select;
    logic [WIDTH-1:0] rf_write_data;
    logic [WIDTH-1:0] rf_read_out;
    logic             busy;
    logic             err;

    regfile_burst_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata(rdata),
        .rf_we(rf_we), .rf_select(rf_select), .rf_write_data(rf_write_data),
        .rf_read_out(rf_read_out), .busy(busy), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file attached to the controller.
    logic [WIDTH-1:0] rf_mem [0:63];
    assign rf_read_out = rf_mem[rf_select];
    always @(posedge clk) if (rf_we) rf_mem[rf_select] <= rf_write_data;

    // Golden image and expected-beat queues.
    logic [WIDTH-1:0] golden [0:DEPTH-1];
    int               exp_wr_idx [$];
    logic [WIDTH-1:0] exp_wr_data [$];
    logic [WIDTH-1:0] exp_rd [$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Cycle-by-cycle protocol monitor, sampled on the falling edge.
    logic             pv;
    logic             pr;
    logic [WIDTH-1:0] pd;
    always @(negedge clk) begin
        if (rst) begin
            pv <= 1'b0;
            pr <= 1'b0;
            pd <= '0;
        end else begin
            check("ready_vs_busy", 64'(cmd_ready), 64'(!busy));
            check("we_vs_wr_handshake", 64'(rf_we), 64'(wdata_ready && wdata_valid));
            if (!busy) check("idle_wdata_ready", 64'(wdata_ready), 64'd0);
            if (rf_we) begin
                if (exp_wr_idx.size() == 0) begin
                    check("unexpected_rf_we", 64'd1, 64'd0);
                end else begin
                    check("wr_index", 64'(rf_select), 64'(exp_wr_idx.pop_front()));
                    check("wr_data", 64'(rf_write_data), 64'(exp_wr_data.pop_front()));
                end
            end
            if (pv && !pr) begin
                check("rvalid_hold", 64'(rdata_valid), 64'd1);
                check("rdata_hold", 64'(rdata), 64'(pd));
            end
            if (pv && pr) check("rvalid_back_to_back", 64'(rdata_valid), 64'd0);
            if (rdata_valid && rdata_ready) begin
                if (exp_rd.size() == 0) check("unexpected_rdata", 64'd1, 64'd0);
                else check("rd_data", 64'(rdata), 64'(exp_rd.pop_front()));
            end
            pv <= rdata_valid;
            pr <= rdata_ready;
            pd <= rdata;
        end
    end

    task automatic issue_cmd(input bit wr, input int a, input int l);
        bit ok;
        cmd_write = wr;
        cmd_addr  = 6'(a);
        cmd_len   = 6'(l);
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_ready_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // gaps: 0 none, 1 random idle beats, 2 one idle beat before word 2.
    task automatic drive_write(input int a, input int l, input int gaps);
        logic [WIDTH-1:0] d;
        int idx;
        bit ok;
        for (int k = 0; k <= l; k++) begin
            if ((gaps == 1 && $urandom_range(0, 2) == 0) || (gaps == 2 && k == 2)) begin
                wdata_valid = 1'b0;
                wdata = $urandom;
                @(posedge clk); #1;
            end
            d   = $urandom;
            idx = (a + k) % DEPTH;
            exp_wr_idx.push_back(idx);
            exp_wr_data.push_back(d);
            golden[idx] = d;
            wdata = d;
            wdata_valid = 1'b1;
            ok = 1'b0;
            for (int t = 0; t < 100; t++) begin
                @(negedge clk);
                if (wdata_ready) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("wdata_ready_timeout", 64'd0, 64'd1);
            @(posedge clk); #1;
        end
        wdata_valid = 1'b0;
    endtask

    task automatic drive_read(input bit stall);
        for (int t = 0; t < 3000; t++) begin
            rdata_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(negedge clk);
            if (!busy) break;
            @(posedge clk); #1;
        end
        rdata_ready = 1'b0;
    endtask

    task automatic count_busy(output int n, output bit e);
        n = 0;
        e = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (err) e = 1'b1;
            if (!busy) break;
            n++;
        end
        if (busy) check("busy_timeout", 64'd1, 64'd0);
    endtask

    // Runs a burst whose command was accepted on the previous rising edge.
    task automatic run_body(input bit wr, input int a, input int l, input int gaps,
                            input bit stall, input bit exp_err, input int exp_busy);
        int bc;
        bit es;
        if (exp_err) begin
            @(negedge clk);
            check("err_pulse", 64'(err), 64'd1);
            check("err_busy", 64'(busy), 64'd0);
            @(negedge clk);
            check("err_clear", 64'(err), 64'd0);
            check("err_busy_after", 64'(busy), 64'd0);
            @(posedge clk); #1;
        end else begin
            if (!wr) for (int k = 0; k <= l; k++) exp_rd.push_back(golden[(a + k) % DEPTH]);
            fork
                begin
                    if (wr) drive_write(a, l, gaps);
                    else drive_read(stall);
                end
                count_busy(bc, es);
            join
            if (exp_busy >= 0) check("busy_cycles", 64'(bc), 64'(exp_busy));
            check("err_quiet", 64'(es), 64'd0);
            check("wr_queue_drained", 64'(exp_wr_idx.size()), 64'd0);
            check("rd_queue_drained", 64'(exp_rd.size()), 64'd0);
            @(posedge clk); #1;
        end
    endtask

    typedef struct {
        bit wr;
        int addr;
        int len;
        bit exp_err;
        int exp_busy;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] d;
        bit ok;
        bit wr, g, s;
        int a, l, eb;

        tbl[0]  = '{1, 2,  3,  0, 4};
        tbl[1]  = '{0, 2,  3,  0, 8};
        tbl[2]  = '{1, 30, 3,  0, 4};
        tbl[3]  = '{0, 30, 3,  0, 8};
        tbl[4]  = '{0, 40, 0,  1, 0};
        tbl[5]  = '{1, 32, 5,  1, 0};
        tbl[6]  = '{1, 31, 0,  0, 1};
        tbl[7]  = '{0, 31, 0,  0, 2};
        tbl[8]  = '{1, 5,  40, 0, 41};
        tbl[9]  = '{0, 5,  40, 0, 82};
        tbl[10] = '{1, 63, 0,  1, 0};
        tbl[11] = '{0, 0,  63, 0, 128};

        for (int i = 0; i < 64; i++) rf_mem[i] <= '0;
        for (int i = 0; i < DEPTH; i++) golden[i] = '0;
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
        wdata_valid = 1'b0; wdata = '0; rdata_ready = 1'b0;

        // Outputs while reset is held.
        #22;
        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rf_we", 64'(rf_we), 64'd0);
        check("rst_rf_select", 64'(rf_select), 64'd0);
        check("rst_wdata_ready", 64'(wdata_ready), 64'd0);
        check("rst_rdata_valid", 64'(rdata_valid), 64'd0);
        check("rst_rdata", 64'(rdata), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // Table of whole bursts with continuous data and an always-ready sink.
        for (int i = 0; i < 12; i++) begin
            issue_cmd(tbl[i].wr, tbl[i].addr, tbl[i].len);
            run_body(tbl[i].wr, tbl[i].addr, tbl[i].len, 0, 1'b0, tbl[i].exp_err, tbl[i].exp_busy);
        end

        // rf_select keeps the last written index once idle.
        issue_cmd(1'b1, 7, 2);
        run_body(1'b1, 7, 2, 0, 1'b0, 1'b0, 3);
        repeat (2) @(posedge clk);
        #1;
        check("idle_select_hold", 64'(rf_select), 64'd9);

        // Read with the sink stalled for five cycles.
        issue_cmd(1'b0, 2, 1);
        exp_rd.push_back(golden[2]);
        exp_rd.push_back(golden[3]);
        rdata_ready = 1'b0;
        ok = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rdata_valid) begin
                ok = 1'b1;
                break;
            end
        end
        check("stall_valid_seen", 64'(ok), 64'd1);
        d = rdata;
        check("stall_first_word", 64'(d), 64'(golden[2]));
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("stall_valid", 64'(rdata_valid), 64'd1);
            check("stall_data", 64'(rdata), 64'(d));
        end
        @(posedge clk); #1;
        drive_read(1'b0);
        check("stall_rd_drained", 64'(exp_rd.size()), 64'd0);
        @(posedge clk); #1;

        // Write with an idle beat in the data stream, then read it back.
        issue_cmd(1'b1, 20, 5);
        run_body(1'b1, 20, 5, 2, 1'b0, 1'b0, 7);
        issue_cmd(1'b0, 20, 5);
        run_body(1'b0, 20, 5, 0, 1'b0, 1'b0, 12);

        // Reset after two of eight write words.
        issue_cmd(1'b1, 10, 7);
        for (int k = 0; k < 2; k++) begin
            d = $urandom;
            exp_wr_idx.push_back(10 + k);
            exp_wr_data.push_back(d);
            golden[10 + k] = d;
            wdata = d;
            wdata_valid = 1'b1;
            @(posedge clk); #1;
        end
        wdata = $urandom;
        wdata_valid = 1'b1;
        #1;
        check("abort_pre_we", 64'(rf_we), 64'd1);
        rst = 1'b1;
        #1;
        check("abort_rf_we", 64'(rf_we), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_cmd_ready", 64'(cmd_ready), 64'd1);
        check("abort_wdata_ready", 64'(wdata_ready), 64'd0);
        exp_wr_idx.delete();
        exp_wr_data.delete();
        wdata_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 6'd10;
        cmd_len   = 6'd3;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        run_body(1'b0, 10, 3, 0, 1'b0, 1'b0, 8);

        // Randomised bursts with random data gaps and sink stalls.
        for (int i = 0; i < 40; i++) begin
            wr = 1'($urandom_range(0, 1));
            a  = $urandom_range(0, 47);
            l  = ($urandom_range(0, 7) == 0) ? $urandom_range(32, 63) : $urandom_range(0, 12);
            g  = 1'($urandom_range(0, 1));
            s  = 1'($urandom_range(0, 1));
            if (wr) eb = g ? -1 : l + 1;
            else    eb = s ? -1 : 2 * (l + 1);
            issue_cmd(wr, a, l);
            run_body(wr, a, l, g ? 1 : 0, s, (a >= DEPTH), eb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_burst_ctrl.md
REGFILE_BURST_CTRL -- requirements
Module: regfile_burst_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 32, data width; DEPTH, default 32, number of register-file entries (legal range 1..64).
REQ-002 clk  in  1  clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 cmd_valid  in  1  command offered; cmd_ready  out  1  command accepted when both are high on a rising edge.
REQ-005 cmd_write  in  1  1 = write burst, 0 = read burst.
REQ-006 cmd_addr  in  6  start entry.
REQ-007 cmd_len  in  6  burst word count minus one (0 = 1 word, 63 = 64 words).
REQ-008 wdata_valid  in  1  / wdata_ready  out  1  / wdata  in  WIDTH  write-data stream.
REQ-009 rdata_valid  out  1  / rdata_ready  in  1  / rdata  out  WIDTH  read-data stream.
REQ-010 rf_we  out  1  / rf_select  out  6  / rf_write_data  out  WIDTH  drive the register-file write-enable, index and data ports.
REQ-011 rf_read_out  in  WIDTH  combinational read data of entry rf_select.
REQ-012 busy  out  1  high in any state other than IDLE.
REQ-013 err  out  1  one-cycle pulse on a rejected command.

Function
REQ-014 The FSM SHALL have the states IDLE, WBURST, RFETCH and RHOLD.
REQ-015 cmd_ready SHALL be high only in IDLE.
REQ-016 On an accepted command with cmd_addr >= DEPTH, the block SHALL pulse err for the next cycle, stay in IDLE and perform no access.
REQ-017 Otherwise the block SHALL load the addr register with cmd_addr and the remaining counter with cmd_len, then enter WBURST (cmd_write=1) or RFETCH (cmd_write=0).
REQ-018 WBURST:
  - wdata_ready SHALL be 1.
  - rf_we SHALL be wdata_valid, combinationally.
  - rf_select SHALL be addr; rf_write_data SHALL be wdata.
REQ-019 Each wdata handshake SHALL advance addr and decrement remaining.
REQ-020 On the handshake with remaining=0, the block SHALL return to IDLE.
REQ-021 RFETCH: rf_select SHALL be addr; the block SHALL capture rf_read_out into rdata, set rdata_valid, and go to RHOLD (one cycle).
REQ-022 RHOLD: rdata and rdata_valid SHALL hold until rdata_ready is high.
REQ-023 On that rdata handshake, the block SHALL clear rdata_valid, then either return to IDLE (remaining=0) or advance addr, decrement remaining and go to RFETCH.
REQ-024 Read throughput SHALL be 1 word per 2 cycles when rdata_ready is held high; write throughput SHALL be 1 word per cycle.
REQ-025 addr SHALL advance as (addr+1) mod DEPTH, wrapping from DEPTH-1 to 0.
REQ-026 Bursts longer than DEPTH SHALL revisit entries in order.
REQ-027 rf_we SHALL be 0 in every state except WBURST.
REQ-028 rf_select SHALL hold its last value in IDLE.
REQ-029 wdata_ready SHALL be 0 outside WBURST.
REQ-030 A new command SHALL NOT be accepted until the FSM is back in IDLE.
REQ-031 The returning-to-IDLE cycle SHALL itself show cmd_ready=0; cmd_ready rises the following cycle.
REQ-032 rdata_valid SHALL never drop without a handshake, and rdata SHALL not change while rdata_valid=1.

Reset
REQ-033 While rst is high, the block SHALL hold state=IDLE, addr=0, remaining=0, rdata=0, rdata_valid=0 and err=0.
REQ-034 While rst is high, the outputs SHALL be: rf_we=0, rf_select=0, wdata_ready=0, busy=0, cmd_ready=1.
REQ-035 rst asserted mid-burst SHALL abort the burst immediately and discard the remaining words.
REQ-036 After release, the first rising edge SHALL be able to accept a command.

Verification
REQ-037 Write 4 words: cmd_write=1, addr=2, len=3, wdata A0..A3 continuous -> rf_we high 4 cycles at rf_select 2,3,4,5 -> busy clears.
REQ-038 Read 4 words: read addr=2, len=3, rdata_ready=1 -> rdata A0..A3, one word every 2 cycles, rdata_valid never high twice back-to-back.
REQ-039 Wrap: write addr=30, len=3 (DEPTH=32) -> rf_select 30,31,0,1; read-back returns the same order.
REQ-040 Backpressure and stalls:
  - read with rdata_ready low 5 cycles -> rdata_valid and rdata stable.
  - write with a wdata_valid gap -> rf_we=0 during the gap, no address advance.
REQ-041 Rejected command: cmd_addr=40 (DEPTH=32) -> err pulses exactly 1 cycle, busy stays 0, no rf_we.
REQ-042 Reset mid-burst: rst asserted after 2 of 8 write words -> rf_we=0 at once, state IDLE; the next command executes normally.
